// File: rtl/bram_16384x1_dp.sv
// True dual-port read-first RAM bank, 16384 x 1, single clock.
// Define BRAM_OUTREG_EN for a second output register stage (latency 2).
module bram_16384x1_dp #(
  parameter int AWIDTH = 14,
  parameter int DWIDTH = 1,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE0,
  input  logic [AWIDTH-1:0] A0,
  input  logic [DWIDTH-1:0] D0,
  input  logic              WE0,
  input  logic [DWIDTH-1:0] WEM0,
  output logic [DWIDTH-1:0] Q0,
  input  logic              CE1,
  input  logic [AWIDTH-1:0] A1,
  input  logic [DWIDTH-1:0] D1,
  input  logic              WE1,
  input  logic [DWIDTH-1:0] WEM1,
  output logic [DWIDTH-1:0] Q1
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH] = '{default: INIT_VAL};
  logic [DWIDTH-1:0] r_q0;
  logic [DWIDTH-1:0] r_q1;
  logic              w_wr0;
  logic              w_wr1;

  assign w_wr0 = CE0 & WE0;
  assign w_wr1 = CE1 & WE1;

  // Port 1 is applied last so it wins bits both ports write.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (w_wr0) begin
        for (int i = 0; i < DWIDTH; i++) begin
          if (WEM0[i]) r_mem[A0][i] <= D0[i];
        end
      end
      if (w_wr1) begin
        for (int i = 0; i < DWIDTH; i++) begin
          if (WEM1[i]) r_mem[A1][i] <= D1[i];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q0 <= '0;
      r_q1 <= '0;
    end else begin
      if (CE0) r_q0 <= r_mem[A0];
      if (CE1) r_q1 <= r_mem[A1];
    end
  end

`ifdef BRAM_OUTREG_EN
  logic              r_ce0_d;
  logic              r_ce1_d;
  logic [DWIDTH-1:0] r_q0_p;
  logic [DWIDTH-1:0] r_q1_p;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ce0_d <= 1'b0;
      r_ce1_d <= 1'b0;
      r_q0_p  <= '0;
      r_q1_p  <= '0;
    end else begin
      r_ce0_d <= CE0;
      r_ce1_d <= CE1;
      if (r_ce0_d) r_q0_p <= r_q0;
      if (r_ce1_d) r_q1_p <= r_q1;
    end
  end

  assign Q0 = r_q0_p;
  assign Q1 = r_q1_p;
`else
  assign Q0 = r_q0;
  assign Q1 = r_q1;
`endif

endmodule

// File: tb/tb_bram_16384x1_dp.sv
// Bench for bram_16384x1_dp: directed vector table, hand sequence,
// and random traffic checked through an expectation queue.
module tb_bram_16384x1_dp;

`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE0, WE0, CE1, WE1;
  logic [13:0] A0, A1;
  logic [0:0]  D0, WEM0, D1, WEM1;
  logic [0:0]  Q0, Q1;

  bram_16384x1_dp dut (
    .CLK(CLK), .RST(RST),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0), .Q0(Q0),
    .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1), .WEM1(WEM1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst;
    logic ce0; logic we0; logic [13:0] a0; logic d0; logic m0;
    logic ce1; logic we1; logic [13:0] a1; logic d1; logic m1;
    logic e0;  logic e1;
  } vec_t;

  typedef struct {
    logic e0;
    logic e1;
    int   id;
  } exp_t;

  exp_t sbq[$];
  logic mdl [16384];
  logic mq0, mq1;
  int   total, bad;

  function automatic vec_t mk(
    input logic rst,
    input logic ce0, input logic we0, input logic [13:0] a0,
    input logic d0, input logic m0,
    input logic ce1, input logic we1, input logic [13:0] a1,
    input logic d1, input logic m1,
    input logic e0, input logic e1);
    vec_t v;
    v.rst = rst;
    v.ce0 = ce0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
    v.ce1 = ce1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic step(input vec_t v, input int id, input bit use_mdl);
    exp_t e;
    @(negedge CLK);
    RST = v.rst;
    CE0 = v.ce0; WE0 = v.we0; A0 = v.a0; D0 = v.d0; WEM0 = v.m0;
    CE1 = v.ce1; WE1 = v.we1; A1 = v.a1; D1 = v.d1; WEM1 = v.m1;
    // reference: reads see the array before this edge's writes
    if (v.rst) begin
      mq0 = 1'b0;
      mq1 = 1'b0;
    end else begin
      if (v.ce0) mq0 = mdl[v.a0];
      if (v.ce1) mq1 = mdl[v.a1];
      if (v.ce0 && v.we0 && v.m0) mdl[v.a0] = v.d0;
      if (v.ce1 && v.we1 && v.m1) mdl[v.a1] = v.d1;
    end
    e.e0 = use_mdl ? mq0 : v.e0;
    e.e1 = use_mdl ? mq1 : v.e1;
    e.id = id;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    if (sbq.size() >= LAT) begin
      e = sbq.pop_front();
      total++;
      if (Q0 !== e.e0) begin
        bad++;
        $display("FAIL q0 step=%0d got=%b want=%b", e.id, Q0, e.e0);
      end
      total++;
      if (Q1 !== e.e1) begin
        bad++;
        $display("FAIL q1 step=%0d got=%b want=%b", e.id, Q1, e.e1);
      end
    end
  endtask

  vec_t tbl [22];
  vec_t hs  [4];
  vec_t rv;

  initial begin
    total = 0;
    bad   = 0;
    mq0   = 1'b0;
    mq1   = 1'b0;
    foreach (mdl[i]) mdl[i] = 1'b0;
    RST = 1'b1;
    CE0 = 0; WE0 = 0; A0 = '0; D0 = '0; WEM0 = '0;
    CE1 = 0; WE1 = 0; A1 = '0; D1 = '0; WEM1 = '0;

    //            rst ce0 we0 a0       d0 m0  ce1 we1 a1       d1 m1  e0 e1
    tbl[0]  = mk(1, 1, 1, 14'h0000, 1, 1,  1, 1, 14'h0000, 1, 1,  0, 0);
    tbl[1]  = mk(1, 1, 0, 14'h0000, 0, 0,  1, 0, 14'h0000, 0, 0,  0, 0);
    tbl[2]  = mk(0, 0, 0, 14'h0000, 0, 0,  1, 0, 14'h0000, 0, 0,  0, 0);
    tbl[3]  = mk(0, 1, 1, 14'h3FFF, 1, 1,  0, 0, 14'h0000, 0, 0,  0, 0);
    tbl[4]  = mk(0, 0, 0, 14'h0000, 0, 0,  1, 0, 14'h3FFF, 0, 0,  0, 1);
    tbl[5]  = mk(0, 0, 0, 14'h0000, 0, 0,  0, 0, 14'h0000, 0, 0,  0, 1);
    tbl[6]  = mk(0, 1, 1, 14'h0005, 1, 0,  0, 0, 14'h0000, 0, 0,  0, 1);
    tbl[7]  = mk(0, 1, 0, 14'h0005, 0, 0,  0, 0, 14'h0000, 0, 0,  0, 1);
    tbl[8]  = mk(0, 1, 1, 14'h0005, 1, 1,  0, 0, 14'h0000, 0, 0,  0, 1);
    tbl[9]  = mk(0, 1, 0, 14'h0005, 0, 0,  0, 0, 14'h0000, 0, 0,  1, 1);
    tbl[10] = mk(0, 1, 1, 14'h0100, 1, 1,  1, 0, 14'h0100, 0, 0,  0, 0);
    tbl[11] = mk(0, 0, 0, 14'h0000, 0, 0,  1, 0, 14'h0100, 0, 0,  0, 1);
    tbl[12] = mk(0, 1, 1, 14'h0100, 0, 1,  0, 0, 14'h0000, 0, 0,  1, 1);
    tbl[13] = mk(0, 0, 0, 14'h0000, 0, 0,  1, 0, 14'h0100, 0, 0,  1, 0);
    tbl[14] = mk(0, 1, 1, 14'h0200, 0, 1,  1, 1, 14'h0200, 1, 1,  0, 0);
    tbl[15] = mk(0, 1, 0, 14'h0200, 0, 0,  0, 0, 14'h0000, 0, 0,  1, 0);
    tbl[16] = mk(1, 1, 1, 14'h0300, 1, 1,  0, 0, 14'h0000, 0, 0,  0, 0);
    tbl[17] = mk(0, 1, 0, 14'h0300, 0, 0,  0, 0, 14'h0000, 0, 0,  0, 0);
    tbl[18] = mk(0, 0, 1, 14'h0010, 1, 1,  0, 0, 14'h0000, 0, 0,  0, 0);
    tbl[19] = mk(0, 1, 0, 14'h0010, 0, 0,  1, 0, 14'h3FFF, 0, 0,  0, 1);
    tbl[20] = mk(0, 0, 0, 14'h0000, 0, 0,  1, 1, 14'h0011, 1, 0,  0, 0);
    tbl[21] = mk(0, 1, 0, 14'h0011, 0, 0,  0, 0, 14'h0000, 0, 0,  0, 0);

    for (int k = 0; k < 22; k++) step(tbl[k], k, 1'b0);

    // reset mid-run clears outputs that were showing 1, memory survives
    hs[0] = mk(0, 1, 0, 14'h3FFF, 0, 0,  1, 0, 14'h0200, 0, 0,  1, 1);
    hs[1] = mk(1, 1, 0, 14'h3FFF, 0, 0,  1, 0, 14'h0200, 0, 0,  0, 0);
    hs[2] = mk(0, 0, 0, 14'h0000, 0, 0,  0, 0, 14'h0000, 0, 0,  0, 0);
    hs[3] = mk(0, 1, 0, 14'h0200, 0, 0,  1, 0, 14'h3FFF, 0, 0,  1, 1);
    for (int k = 0; k < 4; k++) step(hs[k], 100 + k, 1'b0);

    for (int k = 0; k < 300; k++) begin
      rv = mk(($urandom_range(0, 24) == 0),
              1'($urandom), 1'($urandom), 14'h0020 + 14'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 14'h0020 + 14'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 0, 0);
      step(rv, 1000 + k, 1'b1);
    end

    rv = mk(0, 0, 0, 14'h0000, 0, 0,  0, 0, 14'h0000, 0, 0,  0, 0);
    for (int k = 1; k < LAT; k++) step(rv, 5000 + k, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_16384x1_dp.md
Name: bram_16384x1_dp

Overview:
- True dual-port synchronous RAM, 16384 words x 1 bit, single clock.
- Used as the leaf bank primitive of the generated SRAM wrappers: the wrappers tile it horizontally to build data width, and vertically, selected by upper address bits, to build depth.
- Each port has its own chip enable, address, data, write enable, per-bit write mask and registered read output.

Parameters:
- AWIDTH, 14, address width; DEPTH = 2**AWIDTH words.
- DWIDTH, 1, data width per word; WEM width equals DWIDTH.
- INIT_VAL, 0, DWIDTH-bit power-up value of every memory word.

Ports:
- CLK  input  1  single clock; every port samples on its rising edge.
- RST  input  1  synchronous active-high reset.
- CE0  input  1  port 0 chip enable.
- A0  input  AWIDTH  port 0 word address.
- D0  input  DWIDTH  port 0 write data.
- WE0  input  1  port 0 write enable.
- WEM0  input  DWIDTH  port 0 per-bit write mask; 1 = bit written.
- Q0  output  DWIDTH  port 0 registered read data.
- CE1, A1, D1, WE1, WEM1, Q1: identical set for port 1.

Behaviour:
- Storage: DEPTH x DWIDTH array, every word initialised to INIT_VAL. Contents are never cleared by RST.
- Reset: while RST=1 at a rising edge, Q0 and Q1 become 0 and all writes on both ports are suppressed. The first operation after reset is honoured on the edge where RST=0.
- Write, per port p: at a rising edge with RST=0, CEp=1 and WEp=1, each bit i with WEMp[i]=1 takes Dp[i]. Bits with WEMp[i]=0 keep their value. WEp=1 with WEMp all zero performs no write.
- Read, per port p: at a rising edge with RST=0 and CEp=1, Qp takes mem[Ap] as it was before that edge's writes (read-first). Latency is 1 cycle. A read happens on every enabled cycle, including write cycles.
- Same-port write + read: Qp returns the old word and the array takes the new word.
- CEp=0: no access; Qp holds its last value. WEp, Dp and WEMp are ignored.
- Cross-port collision, both ports enabled and addressing the same word:
  - One writes, other reads: the reader gets the old word (read-first); the write completes.
  - Both write: writes merge bit by bit. Where both masks are set, port 1's data wins. Each port's Q returns the old word.
- Addresses are always in range (DEPTH = 2**AWIDTH); no wrap handling is needed.
- No X propagation from unwritten locations; they read INIT_VAL.
- Ports are fully independent apart from the collision rules above.

Optional Feature:
- Macro BRAM_OUTREG_EN.
- When defined: adds a second output register stage on each port. Read latency becomes 2 cycles.
  - The pipeline register for port p loads whenever CEp was 1 on the previous cycle. It holds otherwise.
  - RST clears both stages to 0.
- When undefined: single output register, latency 1, exactly as in Behaviour.

Test Plan:
- Reset then read: assert RST for 2 cycles, then read A1=0x0000 with CE1=1 -> Q1=0 (INIT_VAL). During RST, Q0=Q1=0 even with CE asserted.
- Write/read across ports:
  - Port 0 writes D0=1, WEM0=1, A0=0x3FFF; the next cycle port 1 reads 0x3FFF -> Q1=1 one cycle later.
  - Q1 holds 1 after CE1 drops.
- Write mask: WE0=1, WEM0=0, D0=1 to A0=0x0005, then read -> Q=0. Repeat with WEM0=1 -> Q=1.
- Read-first collision:
  - Same cycle: port 0 writes 1 to 0x0100 (old 0) while port 1 reads 0x0100 -> Q1=0.
  - Next-cycle read -> Q1=1.
  - Same-port write to 0x0100 -> Q0 shows the prior value.
- Dual-write collision: both ports write 0x0200, D0=0, D1=1, masks 1 -> stored value 1 (port 1 wins). Reset mid-operation: RST=1 coincident with WE0=1 at 0x0300 -> word unchanged, Q0=0.
- BRAM_OUTREG_EN build: read 0x3FFF holding 1 -> Q1=1 appears exactly 2 cycles after the CE1 edge. RST clears both stages.
